rr_switch_nxn: RTL and testbench
================================

Name: rr_switch_nxn

Overview:
Parametrised NxN packet switch that generalises the fixed 4x4 switch. Each input port has a FIFO, and each output port has a FIFO. A round-robin arbiter moves one word per cycle from an input head to the output FIFO named by the word's destination field. It replaces the fixed-priority arbiter, the separate demux and the hard-wired depth/thresholds with one configurable block.

Parameters:
NPORT, 4, number of input and output ports (power of 2, 2..8)
DATA_W, 10, word width; the destination field is the top DW = log2(NPORT) bits
DEPTH, 8, entries per FIFO (power of 2, 4..64)
HIGH, 7, almost-full threshold (occupancy >= HIGH)
LOW, 2, almost-empty threshold (occupancy <= LOW)

Ports:
clk  in  1  clock, all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  NPORT*DATA_W  input words; port i uses bits [i*DATA_W +: DATA_W]
push  in  NPORT  write strobe per input FIFO
in_full  out  NPORT  input FIFO full
in_almost_full  out  NPORT  input FIFO occupancy >= HIGH
out_data  out  NPORT*DATA_W  output FIFO heads (first-word-fall-through)
pop  in  NPORT  read strobe per output FIFO
out_empty  out  NPORT  output FIFO empty
out_almost_empty  out  NPORT  output FIFO occupancy <= LOW
err  out  2*NPORT  sticky errors; [i] = push on full input i, [NPORT+i] = pop on empty output i
grant_valid  out  1  a transfer occurs this cycle
grant_src  out  DW  input index being transferred
grant_dst  out  DW  output index being written

Behaviour:
- Reset (reset=0, asynchronous):
  - all pointers and counts go to 0 and err to 0.
  - the round-robin pointer goes to 0, so input 0 is searched first.
  - in_full=0, in_almost_full=0, out_empty=all 1s, out_almost_empty=all 1s, out_data=0, grant_valid=0, grant_src=0, grant_dst=0.
  - FIFO storage contents are not reset; out_data is gated to 0 while a FIFO is empty.
- Each FIFO is a circular buffer with a count of width log2(DEPTH)+1. Pointers wrap from DEPTH-1 to 0.
- Input push:
  - push[i] while in_full[i]=1: the word is dropped and err[i] is set.
  - a pushed word is eligible for arbitration on the next cycle.
- Eligibility: input i is eligible when its FIFO is non-empty and output d (its head's destination field) is not full.
  - Output fullness is evaluated after that cycle's pop, so a pop on a full output frees the slot in the same cycle.
- Arbitration (combinational, registered result):
  - search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NPORT; the first eligible input is granted.
  - on a grant: pop input i, push output d, and set rr_ptr = i+1 mod NPORT.
  - with no grant, rr_ptr holds.
  - at most one transfer per cycle in total, so no two inputs ever write the same output.
- grant_valid, grant_src and grant_dst are registered: they describe the transfer that was committed at the most recent edge.
- Latency with no contention: push at edge t, transfer at edge t+1, word visible on out_data and out_empty=0 after edge t+2.
- Output pop:
  - pop[j] while out_empty[j]=1 is ignored and sets err[NPORT+j].
  - a pop and an arbiter push on the same output in the same cycle keep the count unchanged.
- A simultaneous push and transfer-pop on the same input FIFO keeps its count unchanged. A push on a full input is still rejected even if that input is granted in the same cycle.
- The word is passed unchanged, including its destination bits.
- When reset is deasserted mid-traffic, operation resumes from the empty state; all in-flight words are discarded.

Optional Feature:
Macro: RR_SWITCH_FIXED_PRIO_EN
- Defined: the arbiter uses fixed priority, lowest eligible input index wins, and rr_ptr is removed. This reproduces the legacy switch ordering for regression comparison.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with NPORT=4, DEPTH=8 -> out_empty=4'b1111, out_almost_empty=4'b1111, err=0, grant_valid=0; then push 10'h2A5 on input 0 (dest=2'b10) -> grant_valid=1, src=0, dst=2 one edge later; out_data[2]=10'h2A5 two edges after the push.
- Inputs 0..3 each hold 3 words all destined to output 1 -> grants cycle src 0,1,2,3,0,1,2,3,... and output 1 receives 8 words then blocks (full); popping one word lets exactly one more transfer through, from the next src in order.
- Fill input 2 with 8 words while output 2 is full -> in_full[2]=1, in_almost_full[2]=1 at 7 words; a 9th push sets err[2]=1, which stays set until reset.
- Pop output 3 while empty -> err[7]=1; simultaneous pop and transfer into output 0 holding 4 words -> count stays 4.
- Assert reset low mid-stream with 5 words queued -> all empty flags set on the same cycle, no grant after release until a new push.
- Build with RR_SWITCH_FIXED_PRIO_EN and repeat the second scenario -> all of input 0's words drain first, then input 1, then input 2, then input 3.

Source files
------------

// File: rtl/rr_switch_nxn.sv
// rr_switch_nxn: parametrised NxN packet switch.
// Each input port and each output port has a circular-buffer FIFO. One
// arbiter moves at most one word per cycle from an input head to the output
// FIFO named by the word's top DW bits. The decision is registered together
// with the word, which is written into the output FIFO on the following edge.
// Optional build macro RR_SWITCH_FIXED_PRIO_EN: lowest eligible input index
// wins and the round-robin pointer is removed (legacy ordering).
module rr_switch_nxn #(
  parameter int NPORT  = 4,
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int HIGH   = 7,
  parameter int LOW    = 2,
  localparam int DW    = $clog2(NPORT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT*DATA_W-1:0] in_data,
  input  logic [NPORT-1:0]        push,
  output logic [NPORT-1:0]        in_full,
  output logic [NPORT-1:0]        in_almost_full,
  output logic [NPORT*DATA_W-1:0] out_data,
  input  logic [NPORT-1:0]        pop,
  output logic [NPORT-1:0]        out_empty,
  output logic [NPORT-1:0]        out_almost_empty,
  output logic [2*NPORT-1:0]      err,
  output logic                    grant_valid,
  output logic [DW-1:0]           grant_src,
  output logic [DW-1:0]           grant_dst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_C  = CW'(HIGH);
  localparam logic [CW-1:0] LOW_C   = CW'(LOW);

  typedef logic [DATA_W-1:0] word_t;

  // FIFO storage and control
  word_t          in_mem  [NPORT][DEPTH];
  logic [AW-1:0]  in_wr   [NPORT];
  logic [AW-1:0]  in_rd   [NPORT];
  logic [CW-1:0]  in_cnt  [NPORT];
  word_t          out_mem [NPORT][DEPTH];
  logic [AW-1:0]  out_wr  [NPORT];
  logic [AW-1:0]  out_rd  [NPORT];
  logic [CW-1:0]  out_cnt [NPORT];

  // Per-port combinational helpers
  word_t          head     [NPORT];
  logic [DW-1:0]  head_dst [NPORT];
  logic [CW-1:0]  out_next [NPORT];
  logic [NPORT-1:0] in_push_ok;
  logic [NPORT-1:0] in_pop;
  logic [NPORT-1:0] out_pop_ok;
  logic [NPORT-1:0] out_push;
  logic [NPORT-1:0] eligible;

  // Arbiter result and registered transfer word
  logic           sel_valid;
  logic [DW-1:0]  sel_src;
  logic [DW-1:0]  sel_idx;
  word_t          xfer_word;

`ifndef RR_SWITCH_FIXED_PRIO_EN
  logic [DW-1:0]  rr_ptr;
`endif

  // Status flags, heads and strobe qualification, all from registered state
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the loop can leave a value held (no latch inferred).
    out_data = '0;
    for (int i = 0; i < NPORT; i++) begin
      in_full[i]          = (in_cnt[i] == DEPTH_C);
      in_almost_full[i]   = (in_cnt[i] >= HIGH_C);
      out_empty[i]        = (out_cnt[i] == '0);
      out_almost_empty[i] = (out_cnt[i] <= LOW_C);
      in_push_ok[i]       = push[i] && (in_cnt[i] != DEPTH_C);
      out_pop_ok[i]       = pop[i] && (out_cnt[i] != '0);
      out_push[i]         = grant_valid && (grant_dst == DW'(i));
      head[i]             = in_mem[i][in_rd[i]];
      head_dst[i]         = head[i][DATA_W-1 -: DW];
      if (out_cnt[i] != '0) begin
        out_data[i*DATA_W +: DATA_W] = out_mem[i][out_rd[i]];
      end
    end
  end

  // Output occupancy after this edge (pending write in, pop out) and input eligibility
  always_comb begin
    for (int j = 0; j < NPORT; j++) begin
      out_next[j] = out_cnt[j] + CW'(out_push[j]) - CW'(out_pop_ok[j]);
    end
    for (int i = 0; i < NPORT; i++) begin
      eligible[i] = (in_cnt[i] != '0) && (out_next[head_dst[i]] != DEPTH_C);
    end
  end

  // Arbiter: first eligible input in search order wins
  always_comb begin
    sel_valid = 1'b0;
    sel_src   = '0;
    sel_idx   = '0;
    for (int k = 0; k < NPORT; k++) begin
`ifdef RR_SWITCH_FIXED_PRIO_EN
      sel_idx = DW'(k);
`else
      sel_idx = rr_ptr + DW'(k);
`endif
      if (!sel_valid && eligible[sel_idx]) begin
        sel_valid = 1'b1;
        sel_src   = sel_idx;
      end
    end
    for (int i = 0; i < NPORT; i++) begin
      in_pop[i] = sel_valid && (sel_src == DW'(i));
    end
  end

  // Input FIFO pointers and counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPORT; i++) begin
        in_wr[i]  <= '0;
        in_rd[i]  <= '0;
        in_cnt[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < NPORT; i++) begin
        if (in_push_ok[i]) in_wr[i] <= in_wr[i] + AW'(1);
        if (in_pop[i])     in_rd[i] <= in_rd[i] + AW'(1);
        in_cnt[i] <= in_cnt[i] + CW'(in_push_ok[i]) - CW'(in_pop[i]);
      end
    end
  end

  // Input FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: storage arrays have no reset; the counts define validity and
    // out_data is gated while a FIFO is empty.
    for (int i = 0; i < NPORT; i++) begin
      if (in_push_ok[i]) in_mem[i][in_wr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Output FIFO pointers and counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NPORT; j++) begin
        out_wr[j]  <= '0;
        out_rd[j]  <= '0;
        out_cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        if (out_push[j])   out_wr[j] <= out_wr[j] + AW'(1);
        if (out_pop_ok[j]) out_rd[j] <= out_rd[j] + AW'(1);
        out_cnt[j] <= out_next[j];
      end
    end
  end

  // Output FIFO storage, written with the word committed at the previous edge
  always_ff @(posedge clk) begin
    for (int j = 0; j < NPORT; j++) begin
      if (out_push[j]) out_mem[j][out_wr[j]] <= xfer_word;
    end
  end

  // Registered grant and the word in flight to the output FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_valid <= 1'b0;
      grant_src   <= '0;
      grant_dst   <= '0;
      xfer_word   <= '0;
    end else begin
      grant_valid <= sel_valid;
      if (sel_valid) begin
        grant_src <= sel_src;
        grant_dst <= head_dst[sel_src];
        xfer_word <= head[sel_src];
      end
    end
  end

`ifndef RR_SWITCH_FIXED_PRIO_EN
  // Round-robin pointer moves just past the granted input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (sel_valid) begin
      rr_ptr <= sel_src + DW'(1);
    end
  end
`endif

  // Sticky error flags: push on full input, pop on empty output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (push[i] && in_full[i])  err[i]         <= 1'b1;
        if (pop[i] && out_empty[i]) err[NPORT + i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_switch_nxn.sv
// Directed self-checking bench for rr_switch_nxn (NPORT=4, DATA_W=10, DEPTH=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_rr_switch_nxn;

  localparam int NPORT  = 4;
  localparam int DATA_W = 10;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NPORT*DATA_W-1:0] in_data;
  logic [NPORT-1:0]        push;
  logic [NPORT-1:0]        in_full;
  logic [NPORT-1:0]        in_almost_full;
  logic [NPORT*DATA_W-1:0] out_data;
  logic [NPORT-1:0]        pop;
  logic [NPORT-1:0]        out_empty;
  logic [NPORT-1:0]        out_almost_empty;
  logic [2*NPORT-1:0]      err;
  logic                    grant_valid;
  logic [1:0]              grant_src;
  logic [1:0]              grant_dst;

  int checks   = 0;
  int failures = 0;
  int gq[$];
  int exp_src [12];
  logic [9:0] exp_w [12];

  rr_switch_nxn dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .push             (push),
    .in_full          (in_full),
    .in_almost_full   (in_almost_full),
    .out_data         (out_data),
    .pop              (pop),
    .out_empty        (out_empty),
    .out_almost_empty (out_almost_empty),
    .err              (err),
    .grant_valid      (grant_valid),
    .grant_src        (grant_src),
    .grant_dst        (grant_dst)
  );

  always #5 clk = ~clk;

  // Record every committed grant source, once per cycle
  always @(negedge clk) begin
    if (reset && grant_valid) gq.push_back(int'(grant_src));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] od(input int j);
    return out_data[j*DATA_W +: DATA_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int p, input logic [9:0] w);
    in_data[p*DATA_W +: DATA_W] = w;
  endtask

  task automatic push_word(input int p, input logic [9:0] w);
    set_word(p, w);
    push[p] = 1'b1;
    step();
    push[p] = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    push    = '0;
    pop     = '0;
    in_data = '0;
    repeat (2) step();
    reset = 1'b1;
    step();
    gq.delete();
  endtask

  task automatic wait_nonempty(input int j, input string tag);
    int n = 0;
    while (out_empty[j] && n < 40) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, out_empty[j], 1'b0);
  endtask

  function automatic int gq_at(input int n);
    return (n < gq.size()) ? gq[n] : -1;
  endfunction

  // Four inputs, three words each, all to output 1
  task automatic scen_order();
    int kcnt [4];
    int s;
    do_reset();
`ifdef RR_SWITCH_FIXED_PRIO_EN
    exp_src = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
`else
    exp_src = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
    kcnt = '{0, 0, 0, 0};
    for (int n = 0; n < 12; n++) begin
      s = exp_src[n];
      exp_w[n] = {2'b01, 4'(s), 4'(kcnt[s])};
      kcnt[s]++;
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NPORT; i++) set_word(i, {2'b01, 4'(i), 4'(k)});
      push = '1;
      step();
    end
    push = '0;
    repeat (10) step();
    check("s2_ngrants_full", gq.size(), 8);
    for (int n = 0; n < 8; n++) check($sformatf("s2_src%0d", n), gq_at(n), exp_src[n]);
    check("s2_blocked_gv", grant_valid, 1'b0);
    check("s2_out1_nonempty", out_empty[1], 1'b0);
    check("s2_out1_head", od(1), exp_w[0]);
    pop[1] = 1'b1;
    step();
    pop[1] = 1'b0;
    check("s2_extra_gv", grant_valid, 1'b1);
    check("s2_extra_src", grant_src, exp_src[8]);
    check("s2_extra_dst", grant_dst, 1);
    repeat (4) step();
    check("s2_ngrants_one_more", gq.size(), 9);
    for (int n = 1; n < 12; n++) begin
      wait_nonempty(1, $sformatf("s2_drain%0d", n));
      check($sformatf("s2_word%0d", n), od(1), exp_w[n]);
      pop[1] = 1'b1;
      step();
      pop[1] = 1'b0;
    end
    repeat (3) step();
    check("s2_ngrants_total", gq.size(), 12);
    for (int n = 9; n < 12; n++) check($sformatf("s2_src%0d", n), gq_at(n), exp_src[n]);
    check("s2_out1_empty_end", out_empty[1], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // ---- reset state ----
    reset   = 1'b0;
    push    = '0;
    pop     = '0;
    in_data = '0;
    repeat (2) step();
    check("rst_out_empty", out_empty, 4'hF);
    check("rst_out_aempty", out_almost_empty, 4'hF);
    check("rst_in_full", in_full, 4'h0);
    check("rst_in_afull", in_almost_full, 4'h0);
    check("rst_err", err, 8'h00);
    check("rst_gv", grant_valid, 1'b0);
    check("rst_gsrc", grant_src, 2'd0);
    check("rst_gdst", grant_dst, 2'd0);
    check("rst_out_data", out_data, 40'h0);
    reset = 1'b1;
    step();

    // ---- single word latency: push, transfer one edge later, visible two edges later ----
    set_word(0, 10'h2A5);
    push[0] = 1'b1;
    step();
    push[0] = 1'b0;
    check("s1_gv_early", grant_valid, 1'b0);
    step();
    check("s1_gv", grant_valid, 1'b1);
    check("s1_src", grant_src, 2'd0);
    check("s1_dst", grant_dst, 2'd2);
    check("s1_out2_still_empty", out_empty[2], 1'b1);
    step();
    check("s1_out2_nonempty", out_empty[2], 1'b0);
    check("s1_out2_data", od(2), 10'h2A5);
    check("s1_gv_done", grant_valid, 1'b0);
    pop[2] = 1'b1;
    step();
    pop[2] = 1'b0;
    check("s1_out_empty_after_pop", out_empty, 4'hF);

    // ---- arbitration order and output backpressure ----
    scen_order();

    // ---- input full / almost-full thresholds and sticky errors ----
    do_reset();
    for (int k = 0; k < 8; k++) push_word(0, {2'b10, 8'(k)});
    repeat (6) step();
    check("s3_fill_out2_grants", gq.size(), 8);
    check("s3_out2_aempty", out_almost_empty[2], 1'b0);
    for (int k = 0; k < 8; k++) begin
      push_word(2, {2'b10, 8'(8'h80 + k)});
      if (k == 5) check("s3_afull_at6", in_almost_full[2], 1'b0);
      if (k == 6) begin
        check("s3_afull_at7", in_almost_full[2], 1'b1);
        check("s3_full_at7", in_full[2], 1'b0);
      end
      if (k == 7) check("s3_full_at8", in_full[2], 1'b1);
    end
    check("s3_err_before", err, 8'h00);
    push_word(2, 10'h2FF);
    check("s3_err_push_full", err, 8'h04);
    repeat (3) step();
    check("s3_err_sticky", err, 8'h04);
    check("s3_still_full", in_full[2], 1'b1);
    check("s3_blocked_gv", grant_valid, 1'b0);
    pop[3] = 1'b1;
    step();
    pop[3] = 1'b0;
    check("s3_err_pop_empty", err, 8'h84);
    check("s3_out3_empty", out_empty[3], 1'b1);

    // ---- simultaneous pop and arbiter write on output 0 holding 4 words ----
    do_reset();
    for (int k = 0; k < 4; k++) push_word(1, {2'b00, 8'(k)});
    repeat (4) step();
    check("s4_grants", gq.size(), 4);
    check("s4_aempty_at4", out_almost_empty[0], 1'b0);
    push_word(1, 10'h004);
    step();
    check("s4_xfer_gv", grant_valid, 1'b1);
    check("s4_head", od(0), 10'h000);
    pop[0] = 1'b1;
    step();
    pop[0] = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      check($sformatf("s4_nonempty%0d", n), out_empty[0], 1'b0);
      check($sformatf("s4_word%0d", n), od(0), 10'(n));
      pop[0] = 1'b1;
      step();
      pop[0] = 1'b0;
      check($sformatf("s4_aempty%0d", n), out_almost_empty[0], (4 - n) <= 2);
    end
    check("s4_empty_end", out_empty[0], 1'b1);
    check("s4_err", err, 8'h00);

    // ---- asynchronous reset mid-stream ----
    do_reset();
    for (int k = 0; k < 5; k++) push_word(3, {2'b11, 8'(k)});
    check("s5_out3_busy", out_empty[3], 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("s5_async_out_empty", out_empty, 4'hF);
    check("s5_async_aempty", out_almost_empty, 4'hF);
    check("s5_async_in_full", in_full, 4'h0);
    check("s5_async_gv", grant_valid, 1'b0);
    check("s5_async_out_data", out_data, 40'h0);
    @(negedge clk);
    reset = 1'b1;
    gq.delete();
    repeat (5) step();
    check("s5_no_grant", gq.size(), 0);
    check("s5_still_empty", out_empty, 4'hF);
    push_word(3, 10'h3C1);
    step();
    check("s5_new_gv", grant_valid, 1'b1);
    check("s5_new_src", grant_src, 2'd3);
    check("s5_new_dst", grant_dst, 2'd3);
    step();
    check("s5_new_data", od(3), 10'h3C1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
